// File: rtl/decdigi_pkg.sv
// Shared definitions for the 7-segment digit path.
// Holds the segment codes (bit 6 down to bit 0) used by both the hex-to-digit
// display encoder and the digit-entry decoder, the error code enum reported
// on err_code, and the entry FSM state enum.
package decdigi_pkg;

    localparam logic [6:0] DIGI_0 = 7'b0111111;
    localparam logic [6:0] DIGI_1 = 7'b0011000;
    localparam logic [6:0] DIGI_2 = 7'b1110110;
    localparam logic [6:0] DIGI_3 = 7'b1111100;
    localparam logic [6:0] DIGI_4 = 7'b1011001;
    localparam logic [6:0] DIGI_5 = 7'b1101101;
    localparam logic [6:0] DIGI_6 = 7'b1101111;
    localparam logic [6:0] DIGI_7 = 7'b0111000;
    localparam logic [6:0] DIGI_8 = 7'b1111111;
    localparam logic [6:0] DIGI_9 = 7'b1111101;
    // All segments off: a blank position, not a digit.
    localparam logic [6:0] DIGI_X = 7'b0000000;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_BAD_SEG  = 2'd1,
        ERR_OVERFLOW = 2'd2,
        ERR_COUNT    = 2'd3   // too many digits, or commit with none
    } err_code_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        ERR  = 2'd2
    } state_e;

endpackage

// File: rtl/decdigi2hex_8bit_if.sv
// Bus bundle between a digit-entry source and decdigi2hex_8bit.
//   digi_in/digi_valid : one 7-segment digit code per strobe
//   commit/clear       : finish entry / abort entry
//   hex/hex_valid      : committed value and its one-cycle update pulse
//   err/err_code       : sticky error level and its cause
//   digit_cnt          : digits accepted in the current entry
// master = digit source, slave = decoder.
interface decdigi2hex_8bit_if;

    logic [6:0] digi_in;
    logic       digi_valid;
    logic       commit;
    logic       clear;
    logic [7:0] hex;
    logic       hex_valid;
    logic       err;
    logic [1:0] err_code;
    logic [1:0] digit_cnt;

    modport master (
        output digi_in, digi_valid, commit, clear,
        input  hex, hex_valid, err, err_code, digit_cnt
    );

    modport slave (
        input  digi_in, digi_valid, commit, clear,
        output hex, hex_valid, err, err_code, digit_cnt
    );

endinterface

// File: rtl/decdigi2hex_8bit_seg7_to_bcd.sv
// Combinational 7-segment to BCD decoder.
//   seg      : 7-segment code, bit 6 down to bit 0
//   digit    : decoded decimal value, 0 when seg is not a digit
//   is_digit : seg is one of the ten digit codes
//   is_blank : seg has every segment off
module seg7_to_bcd
    import decdigi_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       is_digit,
    output logic       is_blank
);

    always_comb begin
        digit    = 4'd0;
        is_digit = 1'b1;
        is_blank = 1'b0;
        case (seg)
            DIGI_0:  digit = 4'd0;
            DIGI_1:  digit = 4'd1;
            DIGI_2:  digit = 4'd2;
            DIGI_3:  digit = 4'd3;
            DIGI_4:  digit = 4'd4;
            DIGI_5:  digit = 4'd5;
            DIGI_6:  digit = 4'd6;
            DIGI_7:  digit = 4'd7;
            DIGI_8:  digit = 4'd8;
            DIGI_9:  digit = 4'd9;
            DIGI_X: begin
                is_digit = 1'b0;
                is_blank = 1'b1;
            end
            default: is_digit = 1'b0;
        endcase
    end

endmodule

// File: rtl/decdigi2hex_8bit.sv
// Serial 7-segment digit entry decoder.
// Decimal digits arrive most significant first as 7-segment codes and are
// accumulated into an 8-bit value; commit publishes it on hex with a
// one-cycle hex_valid pulse. Errors park the block in a sticky ERR state
// that only clear or reset leaves.
//   clock, rst_n : rising-edge clock, asynchronous active-low reset
//   bus (slave)  : digit/commit/clear inputs, hex/err/digit_cnt outputs
module decdigi2hex_8bit
    import decdigi_pkg::*;
#(
    parameter int MAX_VALUE = 255   // largest accepted result, 1..255
) (
    input  logic              clock,
    input  logic              rst_n,
    decdigi2hex_8bit_if.slave bus
);

    localparam logic [9:0] MAX_W = 10'(MAX_VALUE);

    state_e    state_q, state_d;
    err_code_e ec_q, ec_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] hex_q, hex_d;
    logic [1:0] cnt_q, cnt_d;
    logic       hv_q, hv_d;

    logic [3:0] seg_digit;
    logic       seg_is_digit;
    logic       seg_is_blank;

    seg7_to_bcd u_seg (
        .seg      (bus.digi_in),
        .digit    (seg_digit),
        .is_digit (seg_is_digit),
        .is_blank (seg_is_blank)
    );

    // acc*10 + d as (acc<<3)+(acc<<1)+d. A digit is only folded in while
    // cnt<3, so acc<=99 here and the 10-bit result (max 999) never wraps.
    logic [9:0] acc_ext;
    logic [9:0] nxt_val;
    assign acc_ext = {2'b00, acc_q};
    assign nxt_val = (acc_ext << 3) + (acc_ext << 1) + {6'b000000, seg_digit};

    always_comb begin
        state_d = state_q;
        ec_d    = ec_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hex_d   = hex_q;
        hv_d    = 1'b0;

        if (bus.clear) begin
            state_d = IDLE;
            ec_d    = ERR_NONE;
            acc_d   = 8'd0;
            cnt_d   = 2'd0;
        end else if (state_q != ERR) begin
            // The digit is resolved first so a same-cycle commit sees the
            // updated accumulator (or the error it raised).
            if (bus.digi_valid && !seg_is_blank) begin
                if (!seg_is_digit) begin
                    state_d = ERR;
                    ec_d    = ERR_BAD_SEG;
                end else if (cnt_q == 2'd3) begin
                    state_d = ERR;
                    ec_d    = ERR_COUNT;
                end else if (nxt_val > MAX_W) begin
                    state_d = ERR;
                    ec_d    = ERR_OVERFLOW;
                end else begin
                    state_d = ACC;
                    acc_d   = nxt_val[7:0];
                    cnt_d   = cnt_q + 2'd1;
                end
            end

            if (bus.commit && state_d != ERR) begin
                if (state_d == ACC) begin
                    hex_d   = acc_d;
                    hv_d    = 1'b1;
                    acc_d   = 8'd0;
                    cnt_d   = 2'd0;
                    state_d = IDLE;
                end else begin
                    state_d = ERR;
                    ec_d    = ERR_COUNT;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ec_q    <= ERR_NONE;
            acc_q   <= 8'd0;
            cnt_q   <= 2'd0;
            hex_q   <= 8'd0;
            hv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ec_q    <= ec_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hex_q   <= hex_d;
            hv_q    <= hv_d;
        end
    end

    assign bus.hex       = hex_q;
    assign bus.hex_valid = hv_q;
    assign bus.err       = (state_q == ERR);
    assign bus.err_code  = ec_q;
    assign bus.digit_cnt = cnt_q;

endmodule

// File: doc/decdigi2hex_8bit.md
Name: decdigi2hex_8bit

Overview:
Serial 7-segment-digit entry decoder. It accepts decimal digits, most significant first, as 7-segment codes, one per strobe, and accumulates them into an 8-bit binary value. On commit it emits the value with a one-cycle valid pulse. It is the inverse path of the team's hex-to-decimal-digit display encoder and uses the same segment encoding. Typical use: loopback checking of display paths and digit-entry front panels.

Parameters:
MAX_VALUE, 255, largest accepted result (legal range 1..255). Any accumulated value above it is an overflow.

Ports:
clock  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
digi_in  input  7  7-segment code of one decimal digit
digi_valid  input  1  digi_in is presented this cycle
commit  input  1  finish entry and emit result
clear  input  1  abort entry, return to IDLE
hex  output  8  committed binary value, held until the next commit
hex_valid  output  1  one-cycle pulse, hex updated
err  output  1  level: block is in ERR state
err_code  output  2  0 NONE, 1 BAD_SEG, 2 OVERFLOW, 3 TOO_MANY_OR_EMPTY
digit_cnt  output  2  digits accepted so far (0..3)

Behaviour:
- One clock domain. rst_n is asynchronous active-low, released synchronously upstream.
- Reset values: hex=0, hex_valid=0, err=0, err_code=0, digit_cnt=0, internal acc=0, state=IDLE.
- Segment codes, bit 6 to bit 0:
  - 0=0111111, 1=0011000, 2=1110110, 3=1111100, 4=1011001
  - 5=1101101, 6=1101111, 7=0111000, 8=1111111, 9=1111101
  - blank=0000000
- States: IDLE (cnt=0), ACC (cnt 1..3), ERR.
- Priority per cycle is clear > digit > commit.
- clear: in any state, next cycle goes to IDLE with acc=0, cnt=0, err=0, err_code=0. No hex_valid. Pending digit and commit in that cycle are discarded.
- digi_valid in IDLE or ACC:
  - Blank code: ignored, no state change.
  - Any other non-digit code: go to ERR with code BAD_SEG.
  - cnt==3: go to ERR with code TOO_MANY_OR_EMPTY.
  - Otherwise nxt = acc*10 + d, computed in 10 bits (max 99*10+9=999, no truncation).
    - nxt > MAX_VALUE: go to ERR with code OVERFLOW.
    - Otherwise acc=nxt[7:0], cnt+1, state ACC.
- Leading zeros count as digits: "0","0","7" gives 7 with cnt=3.
- commit in ACC: hex<=acc and hex_valid=1 on the next cycle, i.e. one cycle after the commit edge. Then acc=0, cnt=0, state IDLE.
- commit in IDLE (no digits): go to ERR with code TOO_MANY_OR_EMPTY. hex is unchanged.
- digi_valid and commit together: the digit is processed first, and the commit uses the updated acc.
  - If the digit causes an error, ERR wins and there is no hex_valid.
  - Example: acc=2, cnt=1, digit 5 plus commit gives hex=25 next cycle.
- ERR is sticky. err=1 and err_code are held, digi_valid and commit are ignored, and only clear or reset exits.
- hex_valid is never asserted for two consecutive cycles without two commits.
- Back-to-back entries with no idle cycle are supported: commit in cycle N and a new digit in N+1 are both accepted.
- Reset mid-entry: everything returns to reset values immediately (asynchronous) and any partial entry is lost.

Decomposition:
- Package decdigi_pkg holds:
  - DIGI_0..DIGI_9 and DIGI_X segment constants, shared with the encoder.
  - err_code enum (ERR_NONE, ERR_BAD_SEG, ERR_OVERFLOW, ERR_COUNT).
  - State enum (IDLE, ACC, ERR).
- One combinational sub-module, seg7_to_bcd: input 7-bit code, outputs 4-bit digit, is_digit, is_blank. Reusable for the display loopback checker.
- The top level holds the FSM, accumulator and multiply-by-10 (shift-add: acc<<3 + acc<<1 + d).

Test Plan:
1. Digits 2,5,5 (1110110, 1101101, 1101101) then commit. Expect hex_valid pulse one cycle after commit, hex=255, cnt returns to 0.
2. Digits 2,5,6 with MAX_VALUE=255. Expect ERR on the third digit, err_code=2, cnt stays 2. Following commit gives no hex_valid. clear then gives err=0.
3. Code 1010101 in ACC. Expect ERR with err_code=1. A subsequent digit 3 is ignored until clear.
4. Commit in IDLE gives err_code=3. Four digits 0,0,1,2 give err_code=3 on the fourth digit.
5. Blank mid-entry and simultaneous events: digits 4, blank, then 2 together with commit. Expect hex=42 with one hex_valid. An immediate next digit 7 is accepted with cnt=1.
6. Assert rst_n low mid-entry (cnt=2) asynchronously. All outputs are 0 within the same cycle, and entry 9 plus commit after release gives hex=9.
